gb_cpu_sequencer: RTL and testbench
===================================

// Module: gb_cpu_sequencer
// PURPOSE
// - Parametrised M-cycle microcode sequencer for the gameboy CPU; successor to the fixed-depth scheduler.
// - Steps through the decoder's per-opcode control table and emits one control word per M-cycle.
// - Handles condition-code abort, 0xCB prefix chaining, interrupt dispatch and HALT with wake-up.
// - Sits between the decoder (schedule_t) and the datapath (control_signals_t).
// PARAMETERS
// - MAX_MCYCLES  6  max control-table entries per instruction; sets schedule_t array depth
// - SW  $clog2(MAX_MCYCLES)  step counter width (localparam, do not override)
// PORTS
// - clk               in   1   M-cycle clock
// - reset             in   1   synchronous, active-high
// - schedule          in   schedule_t  control table for the opcode currently in IR (or ISR when isr_cmd=1)
// - cond_not_met      in   1   condition check failed this M-cycle
// - interrupt_queued  in   1   IME=1 and (IE & IF) != 0
// - interrupt_pending in   1   (IE & IF) != 0, regardless of IME
// - ime               in   1   interrupt master enable
// - halt_req          in   1   decoder: current instruction is HALT
// - control_next      out  control_signals_t  control word for this M-cycle (combinational)
// - step              out  SW  index of current control-table entry
// - instr_done        out  1   last M-cycle of current instruction
// - cb_prefix_o       out  1   IR holds a 0xCB-page opcode
// - isr_cmd           out  1   current instruction is interrupt dispatch
// - halted            out  1   core in HALT
// - sched_err         out  1   one-cycle pulse: schedule.m_cycles out of range
// BEHAVIOUR
// - States: S_FETCH (standalone fetch), S_EXEC, S_HALT.
// - Reset values: state=S_FETCH, step=0, cb_prefix_o=0, isr_cmd=0, halted=0, sched_err=0.
// - After reset, S_FETCH drives control_next=CTRL_FETCH: PC->addr, data->IR, IDU PC+1.
// - S_FETCH -> S_EXEC with step=0 on the next edge, unconditionally.
// - S_EXEC: control_next = schedule.instruction_controls[step].
// - S_EXEC: effective length L = m_cycles; m_cycles=0 is treated as L=1.
// - S_EXEC: m_cycles > MAX_MCYCLES is treated as L=MAX_MCYCLES and pulses sched_err.
// - instr_done = (state==S_EXEC) & (step==L-1).
// - Entry L-1 of every table carries the overlapped opcode fetch.
// - On instr_done the next state is S_EXEC with step=0, and the new IR is live.
// - Otherwise in S_EXEC, step increments by 1.
// - cond_not_met in S_EXEC, not on step L-1: abort; next state S_FETCH, step=0.
// - Abort keeps cb_prefix_o and isr_cmd unchanged, then clears both at the following fetch.
// - cond_not_met in S_FETCH or S_HALT is ignored.
// - cb_prefix_o is updated on instr_done and on S_FETCH exit.
// - cb_prefix_o <= schedule.cb_prefix_next at instr_done; otherwise it is cleared.
// - isr_cmd is updated on the same events as cb_prefix_o.
// - isr_cmd <= interrupt_queued & ~schedule.cb_prefix_next & ~halt_req.
// - A CB prefix always defers an interrupt by one instruction.
// - HALT: instr_done & halt_req -> S_HALT, halted=1.
// - In S_HALT control_next = CTRL_NOP: no bus request, no IDU write.
// - S_HALT exit when interrupt_pending=1.
//   - ime=1: -> S_EXEC step=0 with isr_cmd=1.
//   - ime=0: -> S_FETCH with isr_cmd=0.
//   - halted clears on the exit edge.
// - Simultaneous instr_done & cond_not_met: instr_done wins (normal completion).
// - reset overrides everything on any cycle, including mid-instruction and in S_HALT.
// CONFIGURATION
// - GB_CPU_HALT_BUG_EN defined: if halt_req & ~ime & interrupt_pending at instr_done, S_HALT is not entered.
//   - Instead go to S_FETCH with idu_wren forced 0 for that one fetch; PC is not incremented (DMG halt bug).
// - GB_CPU_HALT_BUG_EN undefined: that case enters S_HALT and exits on the next cycle per the ime=0 rule.
// STRUCTURE
// - gb_cpu_common_pkg gains: seq_state_t enum, CTRL_FETCH and CTRL_NOP control_signals_t constants.
// - schedule_t instruction_controls depth becomes MAX_MCYCLES.
// - Single module; no sub-module (state + step counter + two flag registers).
// TESTING
// - Reset held 2 cycles -> state S_FETCH, control_next==CTRL_FETCH, all flags 0; next cycle step=0.
// - Back-to-back m_cycles=1 x4 -> instr_done=1 every cycle, step stays 0.
// - m_cycles=0 -> treated as 1.
// - m_cycles=3 -> step 0,1,2, instr_done only on step 2, control_next == table[step] each cycle.
// - m_cycles=7 with MAX_MCYCLES=6 -> sched_err pulses, runs 6 steps.
// - JR cc (m_cycles=3) with cond_not_met at step 1 -> next cycle S_FETCH/CTRL_FETCH, then step 0.
// - cb_prefix_next=1 with interrupt_queued=1 -> cb_prefix_o=1, isr_cmd=0.
// - Same case, following instr_done with queue still set -> isr_cmd=1, cb_prefix_o=0.
// - HALT, ime=1; interrupt_pending after 5 cycles -> halted 5 cycles, CTRL_NOP, then S_EXEC step0 isr_cmd=1.
// - HALT, ime=0, pending=1, macro on -> no halt, one fetch with idu_wren=0.
// - Same case, macro off -> halted 1 cycle then S_FETCH.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// rtl/gb_cpu_common_pkg.sv - shared CPU types: control word, per-opcode schedule, sequencer states
package gb_cpu_common_pkg;

  localparam int SCHED_DEPTH = 6;
  localparam int MC_W        = 4;

  typedef enum logic [1:0] {
    IDU_NONE = 2'd0,
    IDU_INC  = 2'd1,
    IDU_DEC  = 2'd2,
    IDU_PASS = 2'd3
  } idu_op_t;

  typedef struct packed {
    logic [1:0] addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_load;
    logic       idu_wren;
    idu_op_t    idu_op;
    logic [3:0] alu_op;
    logic       reg_wren;
  } control_signals_t;

  typedef struct packed {
    logic [MC_W-1:0]                    m_cycles;
    logic                               cb_prefix_next;
    control_signals_t [SCHED_DEPTH-1:0] instruction_controls;
  } schedule_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } seq_state_t;

  // Standalone opcode fetch: PC onto the bus, read data into IR, PC+1 through the IDU.
  localparam control_signals_t CTRL_FETCH = '{
    addr_sel: 2'd0, mem_rd: 1'b1, mem_wr: 1'b0, ir_load: 1'b1,
    idu_wren: 1'b1, idu_op: IDU_INC, alu_op: 4'd0, reg_wren: 1'b0
  };

  localparam control_signals_t CTRL_NOP = '0;

endpackage

// File: rtl/gb_cpu_sequencer.sv
// rtl/gb_cpu_sequencer.sv - M-cycle microcode sequencer; GB_CPU_HALT_BUG_EN enables the DMG halt bug
module gb_cpu_sequencer
  import gb_cpu_common_pkg::*;
#(
  parameter int MAX_MCYCLES = SCHED_DEPTH,
  localparam int SW = $clog2(MAX_MCYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  schedule_t        schedule,
  input  logic             cond_not_met,
  input  logic             interrupt_queued,
  input  logic             interrupt_pending,
  input  logic             ime,
  input  logic             halt_req,
  output control_signals_t control_next,
  output logic [SW-1:0]    step,
  output logic             instr_done,
  output logic             cb_prefix_o,
  output logic             isr_cmd,
  output logic             halted,
  output logic             sched_err
);

  seq_state_t    state, state_nxt;
  logic [SW-1:0] step_nxt;
  logic [SW-1:0] last_step;
  logic          over_range;
  logic          cb_nxt, isr_nxt;
`ifdef GB_CPU_HALT_BUG_EN
  logic          halt_bug, halt_bug_nxt;
`endif

  always_comb begin
    over_range = 32'(schedule.m_cycles) > MAX_MCYCLES;
    if (schedule.m_cycles == '0)
      last_step = '0;
    else if (over_range)
      last_step = SW'(MAX_MCYCLES - 1);
    else
      last_step = SW'(schedule.m_cycles - 1'b1);
  end

  assign instr_done = (state == S_EXEC) && (step == last_step);
  assign sched_err  = (state == S_EXEC) && (step == '0) && over_range;
  assign halted     = (state == S_HALT);

  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    cb_nxt       = cb_prefix_o;
    isr_nxt      = isr_cmd;
    control_next = CTRL_NOP;
`ifdef GB_CPU_HALT_BUG_EN
    halt_bug_nxt = halt_bug;
`endif
    case (state)
      S_FETCH: begin
        control_next = CTRL_FETCH;
`ifdef GB_CPU_HALT_BUG_EN
        control_next.idu_wren = ~halt_bug;
        halt_bug_nxt          = 1'b0;
`endif
        state_nxt = S_EXEC;
        step_nxt  = '0;
        cb_nxt    = 1'b0;
        isr_nxt   = 1'b0;
      end
      S_EXEC: begin
        control_next = schedule.instruction_controls[step];
        // Completion outranks an abort raised on the final entry.
        if (instr_done) begin
          step_nxt  = '0;
          cb_nxt    = schedule.cb_prefix_next;
          isr_nxt   = interrupt_queued & ~schedule.cb_prefix_next & ~halt_req;
          state_nxt = S_EXEC;
          if (halt_req) begin
`ifdef GB_CPU_HALT_BUG_EN
            if (~ime & interrupt_pending) begin
              state_nxt    = S_FETCH;
              halt_bug_nxt = 1'b1;
            end else begin
              state_nxt = S_HALT;
            end
`else
            state_nxt = S_HALT;
`endif
          end
        end else if (cond_not_met) begin
          state_nxt = S_FETCH;
          step_nxt  = '0;
        end else begin
          step_nxt = step + SW'(1);
        end
      end
      S_HALT: begin
        control_next = CTRL_NOP;
        if (interrupt_pending) begin
          step_nxt  = '0;
          cb_nxt    = 1'b0;
          isr_nxt   = ime;
          state_nxt = ime ? S_EXEC : S_FETCH;
        end
      end
      default: begin
        state_nxt = S_FETCH;
        step_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      step        <= '0;
      cb_prefix_o <= 1'b0;
      isr_cmd     <= 1'b0;
`ifdef GB_CPU_HALT_BUG_EN
      halt_bug    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      step        <= step_nxt;
      cb_prefix_o <= cb_nxt;
      isr_cmd     <= isr_nxt;
`ifdef GB_CPU_HALT_BUG_EN
      halt_bug    <= halt_bug_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// tb/tb_gb_cpu_sequencer.sv - directed and randomized bench with an instruction-level reference model
module tb_gb_cpu_sequencer;
  import gb_cpu_common_pkg::*;

  localparam int         MAXC        = 6;
  localparam logic [12:0] FETCH_W     = 13'h5A0;
  localparam logic [12:0] FETCH_BUG_W = 13'h520;
  localparam logic [12:0] NOP_W       = 13'h000;

  logic             clk = 1'b0;
  logic             reset;
  schedule_t        schedule;
  logic             cond_not_met, interrupt_queued, interrupt_pending, ime, halt_req;
  control_signals_t control_next;
  logic [2:0]       step;
  logic             instr_done, cb_prefix_o, isr_cmd, halted, sched_err;
  logic [12:0]      ctrl_bits;

  int total = 0;
  int bad   = 0;

  // model: phase 0 = fetch, 1 = executing entry m_pos, 2 = halted
  int m_phase, m_pos;
  bit m_cb, m_isr, m_bug;

  assign ctrl_bits = control_next;
  always #5 clk = ~clk;

  gb_cpu_sequencer dut (
    .clk(clk), .reset(reset), .schedule(schedule), .cond_not_met(cond_not_met),
    .interrupt_queued(interrupt_queued), .interrupt_pending(interrupt_pending),
    .ime(ime), .halt_req(halt_req), .control_next(control_next), .step(step),
    .instr_done(instr_done), .cb_prefix_o(cb_prefix_o), .isr_cmd(isr_cmd),
    .halted(halted), .sched_err(sched_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len();
    int mc = int'(schedule.m_cycles);
    if (mc == 0) return 1;
    if (mc > MAXC) return MAXC;
    return mc;
  endfunction

  task automatic set_sched(input int mc, input bit cbn);
    schedule.m_cycles       = 4'(mc);
    schedule.cb_prefix_next = cbn;
    for (int i = 0; i < MAXC; i++)
      schedule.instruction_controls[i] = control_signals_t'(13'($urandom));
  endtask

  task automatic compare_model();
    logic [12:0] exp_ctrl;
    int L = eff_len();
    if (m_phase == 0)      exp_ctrl = m_bug ? FETCH_BUG_W : FETCH_W;
    else if (m_phase == 1) exp_ctrl = schedule.instruction_controls[m_pos];
    else                   exp_ctrl = NOP_W;
    chk("control_next", 32'(ctrl_bits), 32'(exp_ctrl));
    chk("step", 32'(step), 32'(m_pos));
    chk("instr_done", 32'(instr_done), 32'(m_phase == 1 && m_pos == L - 1));
    chk("cb_prefix_o", 32'(cb_prefix_o), 32'(m_cb));
    chk("isr_cmd", 32'(isr_cmd), 32'(m_isr));
    chk("halted", 32'(halted), 32'(m_phase == 2));
    chk("sched_err", 32'(sched_err), 32'(m_phase == 1 && m_pos == 0 && schedule.m_cycles > 4'(MAXC)));
  endtask

  task automatic model_update();
    int L = eff_len();
    if (reset) begin
      m_phase = 0; m_pos = 0; m_cb = 0; m_isr = 0; m_bug = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_pos = 0; m_cb = 0; m_isr = 0; m_bug = 0;
    end else if (m_phase == 1) begin
      if (m_pos == L - 1) begin
        m_cb  = schedule.cb_prefix_next;
        m_isr = interrupt_queued & ~schedule.cb_prefix_next & ~halt_req;
        m_pos = 0;
        if (!halt_req) m_phase = 1;
`ifdef GB_CPU_HALT_BUG_EN
        else if (!ime && interrupt_pending) begin m_phase = 0; m_bug = 1; end
`endif
        else m_phase = 2;
      end else if (cond_not_met) begin
        m_phase = 0; m_pos = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end else if (interrupt_pending) begin
      m_cb = 0; m_pos = 0;
      m_isr   = ime;
      m_phase = ime ? 1 : 0;
    end
  endtask

  task automatic tick();
    #1 compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; cond_not_met = 0; interrupt_queued = 0; interrupt_pending = 0; ime = 0; halt_req = 0;
    set_sched(1, 0);
    m_phase = 0; m_pos = 0; m_cb = 0; m_isr = 0; m_bug = 0;
    @(posedge clk);
    @(negedge clk);
    tick();
    reset = 0;
    #1;
    chk("rst_ctrl_fetch", 32'(ctrl_bits), 32'(FETCH_W));
    chk("rst_flags", 32'({instr_done, cb_prefix_o, isr_cmd, halted, sched_err}), 32'd0);
    tick();
    #1 chk("first_exec_step", 32'(step), 32'd0);

    for (int i = 0; i < 4; i++) begin
      set_sched(1, 0);
      #1 chk("b2b_done", 32'(instr_done), 32'd1);
      chk("b2b_step", 32'(step), 32'd0);
      tick();
    end

    set_sched(0, 0);
    #1 chk("mc0_done", 32'(instr_done), 32'd1);
    tick();

    set_sched(3, 0);
    for (int s = 0; s < 3; s++) begin
      #1 chk("mc3_step", 32'(step), 32'(s));
      chk("mc3_done", 32'(instr_done), 32'(s == 2));
      tick();
    end

    set_sched(7, 0);
    for (int s = 0; s < 6; s++) begin
      #1 chk("mc7_err", 32'(sched_err), 32'(s == 0));
      chk("mc7_done", 32'(instr_done), 32'(s == 5));
      tick();
    end

    set_sched(3, 0);
    tick();
    cond_not_met = 1;
    #1 chk("jr_step1", 32'(step), 32'd1);
    tick();
    cond_not_met = 0;
    #1 chk("jr_abort_fetch", 32'(ctrl_bits), 32'(FETCH_W));
    tick();
    set_sched(1, 0);
    #1 chk("jr_refetch_step", 32'(step), 32'd0);
    chk("jr_refetch_done", 32'(instr_done), 32'd1);
    tick();

    set_sched(1, 1);
    interrupt_queued = 1; interrupt_pending = 1; ime = 1;
    tick();
    set_sched(1, 0);
    #1 chk("cb_set", 32'({cb_prefix_o, isr_cmd}), 32'b10);
    tick();
    #1 chk("cb_then_isr", 32'({cb_prefix_o, isr_cmd}), 32'b01);
    interrupt_queued = 0; interrupt_pending = 0;
    tick();

    set_sched(1, 0);
    halt_req = 1;
    tick();
    halt_req = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin interrupt_pending = 1; interrupt_queued = 1; end
      #1 chk("halt_ime1", 32'({halted, ctrl_bits}), 32'({1'b1, NOP_W}));
      tick();
    end
    interrupt_pending = 0; interrupt_queued = 0;
    #1 chk("wake_isr", 32'({halted, isr_cmd, step}), 32'({1'b0, 1'b1, 3'd0}));
    tick();

    ime = 0; interrupt_pending = 1; halt_req = 1;
    set_sched(1, 0);
    tick();
    halt_req = 0;
`ifdef GB_CPU_HALT_BUG_EN
    #1 chk("halt_bug_fetch", 32'({halted, ctrl_bits}), 32'({1'b0, FETCH_BUG_W}));
    tick();
`else
    #1 chk("halt_ime0", 32'({halted, ctrl_bits}), 32'({1'b1, NOP_W}));
    tick();
    #1 chk("halt_ime0_fetch", 32'({halted, ctrl_bits}), 32'({1'b0, FETCH_W}));
    tick();
`endif
    interrupt_pending = 0;

    for (int c = 0; c < 3000; c++) begin
      if (m_phase != 1 || m_pos == 0) begin
        int r = int'($urandom_range(0, 9));
        set_sched(r == 0 ? 0 : (r == 1 ? 7 : int'($urandom_range(1, 6))), $urandom_range(0, 4) == 0);
        halt_req = $urandom_range(0, 9) == 0;
      end
      cond_not_met      = $urandom_range(0, 6) == 0;
      interrupt_pending = $urandom_range(0, 4) == 0;
      ime               = $urandom_range(0, 1) == 1;
      interrupt_queued  = interrupt_pending & ime;
      reset             = $urandom_range(0, 99) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
